// File: rtl/alu_pkg.sv
// Shared types for the RV32 execute unit: opcode encoding, FSM states, op-class helpers.
package alu_pkg;
  localparam int OP_W = 5;

  typedef enum logic [OP_W-1:0] {
    OP_ADD    = 5'd0,
    OP_SLL    = 5'd1,
    OP_SLT    = 5'd2,
    OP_SLTU   = 5'd3,
    OP_XOR    = 5'd4,
    OP_SRL    = 5'd5,
    OP_SRA    = 5'd6,
    OP_OR     = 5'd7,
    OP_AND    = 5'd8,
    OP_SUB    = 5'd9,
    OP_MUL    = 5'd10,
    OP_MULH   = 5'd11,
    OP_MULHSU = 5'd12,
    OP_MULHU  = 5'd13,
    OP_DIV    = 5'd14,
    OP_DIVU   = 5'd15,
    OP_REM    = 5'd16,
    OP_REMU   = 5'd17
  } alu_op_e;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_e;

  function automatic logic is_muldiv(input logic [OP_W-1:0] op);
    return (op >= OP_MUL) && (op <= OP_REMU);
  endfunction
endpackage

// File: rtl/alu_div_seq.sv
// Restoring radix-2 divider on operand magnitudes; the quotient/remainder of the final
// step are presented combinationally alongside done so the caller can register them that cycle.
module alu_div_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            kill,
  input  logic            start,
  input  logic [XLEN-1:0] a_mag,
  input  logic [XLEN-1:0] b_mag,
  input  logic            q_neg,
  input  logic            r_neg,
  output logic            done,
  output logic [XLEN-1:0] quo,
  output logic [XLEN-1:0] rem
);
  localparam int SHW = $clog2(XLEN);

  logic [XLEN-1:0] rq, qq, dd;
  logic            qn, rn, busy;
  logic [SHW-1:0]  cnt;

  logic [XLEN:0]   shifted;
  logic            ge;
  logic [XLEN-1:0] r_nx, q_nx;

  // Partial remainder stays below the divisor, so the shifted value fits XLEN+1 bits.
  always_comb begin
    shifted = {rq, qq[XLEN-1]};
    ge      = shifted >= {1'b0, dd};
    r_nx    = ge ? (shifted[XLEN-1:0] - dd) : shifted[XLEN-1:0];
    q_nx    = {qq[XLEN-2:0], ge};
  end

  assign done = busy && (cnt == '1);
  assign quo  = qn ? (-q_nx) : q_nx;
  assign rem  = rn ? (-r_nx) : r_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rq   <= '0;
      qq   <= '0;
      dd   <= '0;
      qn   <= 1'b0;
      rn   <= 1'b0;
      busy <= 1'b0;
      cnt  <= '0;
    end else if (kill) begin
      busy <= 1'b0;
    end else if (start) begin
      rq   <= '0;
      qq   <= a_mag;
      dd   <= b_mag;
      qn   <= q_neg;
      rn   <= r_neg;
      busy <= 1'b1;
      cnt  <= '0;
    end else if (busy) begin
      rq  <= r_nx;
      qq  <= q_nx;
      cnt <= cnt + 1'b1;
      if (cnt == '1) busy <= 1'b0;
    end
  end
endmodule

// File: rtl/alu_muldiv_seq.sv
// RV32 EX unit: single-cycle base ops, XLEN-cycle shift-add multiplier, optional iterative divider.
// Define ALU_DIV_EN to build the divider; otherwise ops 14-17 report illegal.
module alu_muldiv_seq
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [OP_W-1:0] in_op,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            out_illegal
);
  localparam int SHW = $clog2(XLEN);
  localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

  state_e          state;
  logic [XLEN-1:0] res_q;
  logic            ill_q;
  logic            accept;

  assign in_ready    = ~flush & ((state == IDLE) | ((state == DONE) & out_ready));
  assign accept      = in_valid & in_ready;
  assign out_valid   = (state == DONE);
  assign out_result  = res_q;
  assign out_illegal = ill_q;

  // ---- base ops ----
  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] base_res;
  assign shamt = in_b[SHW-1:0];

  always_comb begin
    base_res = '0;
    case (in_op)
      OP_ADD:  base_res = in_a + in_b;
      OP_SLL:  base_res = in_a << shamt;
      OP_SLT:  base_res = {{(XLEN-1){1'b0}}, $signed(in_a) < $signed(in_b)};
      OP_SLTU: base_res = {{(XLEN-1){1'b0}}, in_a < in_b};
      OP_XOR:  base_res = in_a ^ in_b;
      OP_SRL:  base_res = in_a >> shamt;
      OP_SRA:  base_res = $signed(in_a) >>> shamt;
      OP_OR:   base_res = in_a | in_b;
      OP_AND:  base_res = in_a & in_b;
      OP_SUB:  base_res = in_a - in_b;
      default: base_res = '0;
    endcase
  end

  // ---- op classification and operand magnitudes ----
  logic            op_mul, legal, a_sgn, b_sgn, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;

  assign op_mul = is_muldiv(in_op) && (in_op < OP_DIV);
`ifdef ALU_DIV_EN
  assign legal  = (in_op <= OP_REMU);
`else
  assign legal  = (in_op <= OP_MULHU);
`endif
  assign a_sgn = (in_op == OP_MULH) | (in_op == OP_MULHSU) | (in_op == OP_DIV) | (in_op == OP_REM);
  assign b_sgn = (in_op == OP_MULH) | (in_op == OP_DIV) | (in_op == OP_REM);
  assign a_neg = a_sgn & in_a[XLEN-1];
  assign b_neg = b_sgn & in_b[XLEN-1];
  assign a_mag = a_neg ? (-in_a) : in_a;
  assign b_mag = b_neg ? (-in_b) : in_b;

  // ---- multiplier: {mhi,mlo} shifts right, mlo starts as the multiplier ----
  logic [XLEN-1:0]   mhi, mlo, mcand;
  logic              mneg, mhigh;
  logic [SHW-1:0]    cnt;
  logic [XLEN:0]     msum;
  logic [XLEN-1:0]   mhi_nx, mlo_nx;
  logic [2*XLEN-1:0] mprod;

  always_comb begin
    msum   = {1'b0, mhi} + (mlo[0] ? {1'b0, mcand} : '0);
    mhi_nx = msum[XLEN:1];
    mlo_nx = {msum[0], mlo[XLEN-1:1]};
    mprod  = mneg ? (-{mhi_nx, mlo_nx}) : {mhi_nx, mlo_nx};
  end

`ifdef ALU_DIV_EN
  // ---- divider hookup; zero divisor and MIN/-1 bypass the iteration ----
  logic            op_div, want_rem, div_by0, div_ovf, div_special, div_start, div_done;
  logic [XLEN-1:0] div_quo, div_rem, spec_res;

  assign op_div      = is_muldiv(in_op) && (in_op >= OP_DIV);
  assign div_by0     = (in_b == '0);
  assign div_ovf     = a_sgn && (in_a == XMIN) && (in_b == '1);
  assign div_special = div_by0 | div_ovf;
  assign spec_res    = ((in_op == OP_DIV) | (in_op == OP_DIVU)) ? (div_by0 ? '1 : XMIN)
                                                                 : (div_by0 ? in_a : '0);
  assign div_start   = accept & legal & op_div & ~div_special;

  alu_div_seq #(.XLEN(XLEN)) u_div (
    .clk   (clk),
    .rst_n (rst_n),
    .kill  (flush),
    .start (div_start),
    .a_mag (a_mag),
    .b_mag (b_mag),
    .q_neg (a_neg ^ b_neg),
    .r_neg (a_neg),
    .done  (div_done),
    .quo   (div_quo),
    .rem   (div_rem)
  );
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      res_q <= '0;
      ill_q <= 1'b0;
      mhi   <= '0;
      mlo   <= '0;
      mcand <= '0;
      mneg  <= 1'b0;
      mhigh <= 1'b0;
      cnt   <= '0;
`ifdef ALU_DIV_EN
      want_rem <= 1'b0;
`endif
    end else if (flush) begin
      state <= IDLE;
    end else if (accept) begin
      ill_q <= 1'b0;
      if (!legal) begin
        state <= DONE;
        res_q <= '0;
        ill_q <= 1'b1;
      end else if (op_mul) begin
        state <= MUL;
        mhi   <= '0;
        mlo   <= b_mag;
        mcand <= a_mag;
        mneg  <= a_neg ^ b_neg;
        mhigh <= (in_op != OP_MUL);
        cnt   <= '0;
`ifdef ALU_DIV_EN
      end else if (op_div) begin
        want_rem <= (in_op == OP_REM) | (in_op == OP_REMU);
        if (div_special) begin
          state <= DONE;
          res_q <= spec_res;
        end else begin
          state <= DIV;
        end
`endif
      end else begin
        state <= DONE;
        res_q <= base_res;
      end
    end else begin
      case (state)
        DONE: if (out_ready) state <= IDLE;
        MUL: begin
          mhi <= mhi_nx;
          mlo <= mlo_nx;
          cnt <= cnt + 1'b1;
          if (cnt == '1) begin
            state <= DONE;
            res_q <= mhigh ? mprod[2*XLEN-1:XLEN] : mprod[XLEN-1:0];
          end
        end
`ifdef ALU_DIV_EN
        DIV: if (div_done) begin
          state <= DONE;
          res_q <= want_rem ? div_rem : div_quo;
        end
`endif
        default: ;
      endcase
    end
  end
endmodule
